// File: rtl/spike_event_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tinyodin_evt_pkg
//  Description : Shared types and constants for the spike event buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package tinyodin_evt_pkg;

    localparam int PKG_TICK_W = 8;
    localparam int PKG_ADDR_W = 8;
    localparam int OVF_W      = 16;

    // One captured spike: timestamp in the upper bits, neuron index below.
    typedef struct packed {
        logic [PKG_TICK_W-1:0] tick;
        logic [PKG_ADDR_W-1:0] addr;
    } spike_evt_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } evt_state_e;

    // Saturating increment so the drop counter never wraps back to a small value.
    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_event_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : spike_event_buffer_if
//  Description : Valid/ready event stream from the buffer to the host reader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spike_event_buffer_if #(
    parameter int DATA_W = 16
) ();

    logic              evt_valid_o;
    logic              evt_ready_i;
    logic [DATA_W-1:0] evt_data_o;

    // Event producer side (the buffer).
    modport master (
        output evt_valid_o,
        output evt_data_o,
        input  evt_ready_i
    );

    // Event consumer side (the host reader).
    modport slave (
        input  evt_valid_o,
        input  evt_data_o,
        output evt_ready_i
    );

endinterface
`default_nettype wire

// File: rtl/spike_event_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_fwft
//  Description : Single-clock first-word-fall-through FIFO. A write into a full
//                FIFO is accepted when a read happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_wr_en,
    input  wire logic [WIDTH-1:0] i_wr_data,
    output logic                  o_wr_accept,
    output logic                  o_rd_valid,
    input  wire logic             i_rd_ready,
    output logic      [WIDTH-1:0] o_rd_data,
    output logic      [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    // Ready is ignored while nothing is presented.
    assign w_pop   = !w_empty && i_rd_ready;
    // The slot freed by a same-cycle read can take the incoming word.
    assign w_push  = i_wr_en && (!w_full || w_pop);

    assign o_wr_accept = w_push;
    assign o_rd_valid  = !w_empty;
    assign o_count     = r_count;
    // Drive zero when empty so the bus is quiet after reset or flush.
    assign o_rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over any transfer.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_event_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : spike_event_buffer
//  Description : Captures output spikes with their time-step, queues them and
//                streams them to the host; raises a done interrupt once
//                inference has finished and the queue has been drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_event_buffer
    import tinyodin_evt_pkg::*;
#(
    parameter  int N      = 256,
    parameter  int DEPTH  = 16,
    parameter  int TICK_W = 8,
    localparam int ADDR_W = $clog2(N),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              spike_pushback_i,
    input  wire logic [ADDR_W-1:0] spike_pushback_addr_i,
    input  wire logic [TICK_W-1:0] tick_i,
    input  wire logic              inference_done_i,
    input  wire logic              clear_i,
    spike_event_buffer_if.master   evt_if,
    output logic       [CNT_W-1:0] evt_count_o,
    output logic       [OVF_W-1:0] overflow_cnt_o,
    output logic                   busy_o,
    output logic                   done_irq_o
);

    localparam int c_DATA_W = TICK_W + ADDR_W;

    evt_state_e r_state;
    evt_state_e w_state_nxt;

    logic              r_done_d;
    logic              r_irq;
    logic [OVF_W-1:0]  r_ovf;

    logic              w_push_req;
    logic              w_irq_nxt;
    logic              w_wr_accept;
    logic              w_rd_valid;
    logic [c_DATA_W-1:0] w_rd_data;
    logic [CNT_W-1:0]  w_count;
    logic              w_pop;
    logic              w_done_rise;
    logic              w_drain_empty;
    logic              w_drop;

    assign w_pop       = w_rd_valid && evt_if.evt_ready_i;
    assign w_done_rise = inference_done_i && !r_done_d;
    // Queue is empty after this edge: already empty, or the last entry leaves now.
    assign w_drain_empty = (w_count == '0) || ((w_count == CNT_W'(1)) && w_pop);
    assign w_drop      = w_push_req && !w_wr_accept;

    sync_fifo_fwft #(
        .WIDTH (c_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_clr       (clear_i),
        .i_wr_en     (w_push_req),
        .i_wr_data   ({tick_i, spike_pushback_addr_i}),
        .o_wr_accept (w_wr_accept),
        .o_rd_valid  (w_rd_valid),
        .i_rd_ready  (evt_if.evt_ready_i),
        .o_rd_data   (w_rd_data),
        .o_count     (w_count)
    );

    // State register, IRQ pulse and inference_done edge history.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state  <= RUN;
            r_irq    <= 1'b0;
            r_done_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_irq    <= w_irq_nxt;
            r_done_d <= inference_done_i;
        end
    end

    // Next-state, push gating and IRQ request; clear overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_push_req  = 1'b0;
        w_irq_nxt   = 1'b0;
        case (r_state)
            RUN: begin
                w_push_req = spike_pushback_i;
                if (w_done_rise) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_empty) begin
                    w_state_nxt = DONE;
                    w_irq_nxt   = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
        if (clear_i) begin
            w_push_req  = 1'b0;
            w_state_nxt = RUN;
            w_irq_nxt   = 1'b0;
        end
    end

    // Count spikes lost to a full queue while running.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_ovf <= '0;
        end else if (w_drop) begin
            r_ovf <= sat_inc(r_ovf);
        end
    end

    assign evt_if.evt_valid_o = w_rd_valid;
    assign evt_if.evt_data_o  = w_rd_data;
    assign evt_count_o        = w_count;
    assign overflow_cnt_o     = r_ovf;
    assign busy_o             = (r_state != DONE);
    assign done_irq_o         = r_irq;

endmodule
`default_nettype wire
